// File: rtl/classifier_pkg.sv
// Shared types for stream_classifier: bin indices, FSM states and drop counter width.
package classifier_pkg;

    localparam int NUM_BINS = 4;
    localparam int DROP_W   = 8;

    typedef logic [1:0] bin_t;

    typedef enum logic [1:0] {
        BIN_DIV_A = 2'd0,
        BIN_DIV_B = 2'd1,
        BIN_EVEN  = 2'd2,
        BIN_ODD   = 2'd3
    } bin_e;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/bin_fifo.sv
// Single-bin FIFO: DEPTH x DATA_W storage with occupancy count and a synchronous clear.
module bin_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign count   = count_reg;
    // Combinational read so the drain stream can sustain one beat per cycle.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stream_classifier.sv
// Collects a framed stream into four divisibility/parity bins, then drains them in bin order.
// Optional: define STREAM_CLASSIFIER_ZERO_DROP_EN to silently discard zero-valued inputs.
module stream_classifier
    import classifier_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DIV_A  = 6,
    parameter int DIV_B  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_bin,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] DIV_A_V = DATA_W'(DIV_A);
    localparam logic [DATA_W-1:0] DIV_B_V = DATA_W'(DIV_B);

    function automatic bin_t classify(input logic [DATA_W-1:0] v);
        if (v % DIV_A_V == '0)      return BIN_DIV_A;
        else if (v % DIV_B_V == '0) return BIN_DIV_B;
        else if (!v[0])             return BIN_EVEN;
        else                        return BIN_ODD;
    endfunction

    state_e state_reg, state_next;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_count_reg;

    logic [NUM_BINS-1:0]             wr_en, rd_en, full, empty;
    logic [NUM_BINS-1:0][CNT_W-1:0]  count;
    logic [NUM_BINS-1:0][DATA_W-1:0] rd_data;

    bin_t in_bin, cur_bin;
    logic accept, zero_skip, store_ok, drop, any_data, higher_data, clear, out_fire;

    assign in_bin   = classify(in_data);
    assign in_ready = reset && (state_reg == COLLECT);
    assign accept   = in_valid && in_ready;

`ifdef STREAM_CLASSIFIER_ZERO_DROP_EN
    assign zero_skip = (in_data == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign store_ok = accept && !zero_skip && !full[in_bin];
    assign drop     = accept && !zero_skip &&  full[in_bin];
    assign clear    = (state_reg == DONE);
    assign any_data = ~&empty;

    // Drained bins empty out, so the lowest non-empty bin is always the current one.
    always_comb begin
        cur_bin     = '0;
        higher_data = 1'b0;
        for (int i = NUM_BINS - 1; i >= 0; i--) begin
            if (!empty[i]) cur_bin = bin_t'(i);
        end
        for (int i = 0; i < NUM_BINS; i++) begin
            if (!empty[i] && (bin_t'(i) > cur_bin)) higher_data = 1'b1;
        end
    end

    assign out_valid  = (state_reg == DRAIN) && any_data;
    assign out_data   = out_valid ? rd_data[cur_bin] : '0;
    assign out_bin    = out_valid ? cur_bin : '0;
    assign out_last   = out_valid && (count[cur_bin] == CNT_W'(1)) && !higher_data;
    assign out_fire   = out_valid && out_ready;
    assign busy       = (state_reg == DRAIN);
    assign done       = (state_reg == DONE);
    assign overflow   = overflow_reg;
    assign drop_count = drop_count_reg;

    for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
        assign wr_en[gi] = store_ok && (in_bin == bin_t'(gi));
        assign rd_en[gi] = out_fire && (cur_bin == bin_t'(gi));

        bin_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .wr_en   (wr_en[gi]),
            .wr_data (in_data),
            .rd_en   (rd_en[gi]),
            .rd_data (rd_data[gi]),
            .count   (count[gi]),
            .full    (full[gi]),
            .empty   (empty[gi])
        );
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (accept && in_last) state_next = DRAIN;
            DRAIN: begin
                if (!any_data)                 state_next = DONE;
                else if (out_fire && out_last) state_next = DONE;
            end
            DONE:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_count_reg != '1) drop_count_reg <= drop_count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_classifier.sv
// Scoreboard bench for stream_classifier (DEPTH=4 so the overflow case fits a short frame).
module tb_stream_classifier;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_bin;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [7:0]        drop_count;

    always #5 clk = ~clk;

    stream_classifier #(
        .DATA_W (DATA_W),
        .DEPTH  (4),
        .DIV_A  (6),
        .DIV_B  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bin    (out_bin),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    typedef struct packed {
        logic       last;
        logic [1:0] bin;
        logic [7:0] data;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    beats_seen = 0;
    logic  ready_level = 1'b1;
    logic  bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int    bp_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [7:0] d, input logic [1:0] b, input logic l);
        beat_t e;
        e.data = d;
        e.bin  = b;
        e.last = l;
        sb.push_back(e);
    endfunction

    always @(posedge clk) begin
        #2;
        if (bp_en) begin
            out_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end else begin
            out_ready = ready_level;
        end
    end

    // Monitor: pops an expectation per handshake and checks values held during stalls.
    beat_t held;
    logic  stalled = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t exp;
        if (reset && out_valid) begin
            cur = {out_last, out_bin, out_data};
            if (stalled) check("hold_stable", 32'(cur), 32'(held));
            if (out_ready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data=%0d bin=%0d last=%0d want none",
                             out_data, out_bin, out_last);
                end else begin
                    exp = sb.pop_front();
                    check("beat", 32'(cur), 32'(exp));
                    $display("beat data=%0d bin=%0d last=%0d", out_data, out_bin, out_last);
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = cur;
            end
        end else begin
            if (reset && stalled) check("valid_dropped_in_stall", 32'(out_valid), 32'd1);
            stalled = 1'b0;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("sent data=%0d last=%0d", d, l);
    endtask

    task automatic send_basic();
        send_beat(8'd5, 1'b0);
        send_beat(8'd4, 1'b0);
        send_beat(8'd2, 1'b0);
        send_beat(8'd1, 1'b0);
        send_beat(8'd10, 1'b0);
        send_beat(8'd0, 1'b0);
        send_beat(8'd12, 1'b0);
        send_beat(8'd3, 1'b1);
    endtask

    task automatic push_basic();
        push(8'd0, 2'd0, 1'b0);
        push(8'd12, 2'd0, 1'b0);
        push(8'd3, 2'd1, 1'b0);
        push(8'd4, 2'd2, 1'b0);
        push(8'd2, 2'd2, 1'b0);
        push(8'd10, 2'd2, 1'b0);
        push(8'd5, 2'd3, 1'b0);
        push(8'd1, 2'd3, 1'b1);
    endtask

    // Waits for the done pulse, checking flags on DRAIN entry and clean state afterwards.
    task automatic wait_done(input string tag, input int exp_ovf, input int exp_drop,
                             input int exp_drain);
        int  n = 0;
        int  drain_cycles = 0;
        bit  seen = 1'b0;
        bit  flags_checked = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            n++;
            if (busy) begin
                drain_cycles++;
                if (!flags_checked) begin
                    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
                    check({tag, "_drop_count"}, 32'(drop_count), 32'(exp_drop));
                    check({tag, "_in_ready_drain"}, 32'(in_ready), 32'd0);
                    flags_checked = 1'b1;
                end
            end
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_drain >= 0) check({tag, "_drain_cycles"}, 32'(drain_cycles), 32'(exp_drain));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_overflow_cleared"}, 32'(overflow), 32'd0);
        check({tag, "_drop_cleared"}, 32'(drop_count), 32'd0);
        $display("frame %s complete", tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic frame with continuous ready.
        push_basic();
        send_basic();
        wait_done("basic", 0, 0, 8);

        // Overflow: bin3 fills with 1,5,7,11; 13 is dropped but still ends the frame.
        push(8'd1, 2'd3, 1'b0);
        push(8'd5, 2'd3, 1'b0);
        push(8'd7, 2'd3, 1'b0);
        push(8'd11, 2'd3, 1'b1);
        send_beat(8'd1, 1'b0);
        send_beat(8'd5, 1'b0);
        send_beat(8'd7, 1'b0);
        send_beat(8'd11, 1'b0);
        send_beat(8'd13, 1'b1);
        wait_done("overflow", 1, 1, 4);

        // Backpressure with ready pattern 1,0,0,1.
        bp_en  = 1'b1;
        bp_idx = 0;
        push_basic();
        send_basic();
        wait_done("backpressure", 0, 0, -1);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Zero frame.
`ifdef STREAM_CLASSIFIER_ZERO_DROP_EN
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b1);
        wait_done("zero", 0, 0, 1);
`else
        push(8'd0, 2'd0, 1'b0);
        push(8'd0, 2'd0, 1'b1);
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b1);
        wait_done("zero", 0, 0, 2);
`endif

        // Reset after three drained beats.
        base = beats_seen;
        push(8'd0, 2'd0, 1'b0);
        push(8'd12, 2'd0, 1'b0);
        push(8'd3, 2'd1, 1'b0);
        send_basic();
        n = 0;
        while (beats_seen < base + 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midrst_three_beats", 32'(beats_seen - base), 32'd3);
        ready_level = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        ready_level = 1'b1;
        #1;
        check("midrst_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done), 32'd0);
        push(8'd9, 2'd1, 1'b1);
        send_beat(8'd9, 1'b1);
        wait_done("after_reset", 0, 0, 1);

        // Back-to-back frame launched in the first COLLECT cycle after done.
        push(8'd6, 2'd0, 1'b0);
        push(8'd7, 2'd3, 1'b1);
        send_beat(8'd6, 1'b0);
        send_beat(8'd7, 1'b1);
        wait_done("back_to_back", 0, 0, 2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_classifier.md
Name: stream_classifier

Overview:
- Parametrised successor to the fixed odd/even, div-3/div-6 sorter.
- Accepts a valid/ready stream of unsigned DATA_W-bit values terminated by a last flag, classifies each value into one of four bins, and buffers up to DEPTH entries per bin.
- After the last input, drains all bins in bin order over a valid/ready output stream, then returns to collecting.
- Sits between a data source (ROM reader or upstream stream) and a downstream consumer.

Parameters:
- DATA_W, 8, width of data values.
- DEPTH, 8, entries per bin; power of two, >= 2.
- DIV_A, 6, primary divisor (bin 0).
- DIV_B, 3, secondary divisor (bin 1); DIV_A and DIV_B nonzero constants.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous reset, active-low: state clears on the rising clk edge where reset==0.
- in_valid  in  1  input value present.
- in_ready  out  1  block accepts input.
- in_data  in  DATA_W  input value, unsigned.
- in_last  in  1  final value of the frame.
- out_valid  out  1  drain output present.
- out_ready  in  1  consumer accepts output.
- out_data  out  DATA_W  drained value.
- out_bin  out  2  bin index of out_data.
- out_last  out  1  final drained value of the frame.
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- overflow  out  1  sticky per frame; a value was dropped because its bin was full.
- drop_count  out  8  values dropped this frame; saturates at 255.

Behaviour:
- Reset values: in_ready=0 during reset, then 1 in COLLECT; all other outputs 0; all bin counts 0; state COLLECT.
- Classification uses first match, in this order:
  - bin0: value % DIV_A == 0.
  - bin1: value % DIV_B == 0.
  - bin2: value even.
  - bin3: value odd.
  - Zero therefore lands in bin0.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready, the value is written to bin[b][wr_ptr[b]] and count[b] increments; both are visible the next cycle.
  - If count[b]==DEPTH, the value is dropped instead: overflow<=1 and drop_count increments (saturating). The block never stalls input because of a full bin.
  - An accepted beat with in_last=1 moves the state to DRAIN on the next cycle. A dropped last beat still ends the frame.
- DRAIN:
  - in_ready=0.
  - The read pointer scans bins 0 to 3 and skips empty bins. Within each bin, values are output in arrival order (FIFO).
  - out_data and out_bin come from the current bin and read entry, and are held stable while out_valid && !out_ready.
  - Each out_valid&&out_ready advances the read pointer. out_last=1 on the final entry of the highest-numbered non-empty bin.
  - The handshake on the out_last beat moves the state to DONE.
  - If all bins are empty at DRAIN entry, the state goes to DONE the next cycle with no output beats.
- DONE:
  - Lasts one cycle: done=1.
  - Clears counts, pointers, overflow and drop_count; next state is COLLECT.
- overflow and drop_count remain readable throughout DRAIN.
- Reset asserted mid-frame (any state) discards all buffered data immediately; no done pulse.
- Throughput: 1 beat/cycle in both COLLECT and DRAIN.

Optional Feature:
- Macro: STREAM_CLASSIFIER_ZERO_DROP_EN.
- Defined: an accepted value of 0 is discarded. It is not stored, not counted in drop_count, and does not set overflow. in_last on a zero beat still ends the frame.
- Undefined: zero is classified normally into bin0.

Decomposition:
- Shared package `classifier_pkg` holds:
  - bin index typedef (2 bits);
  - bin enum constants BIN_DIV_A=0, BIN_DIV_B=1, BIN_EVEN=2, BIN_ODD=3;
  - FSM state enum COLLECT/DRAIN/DONE;
  - the drop counter width constant (8).
- One sub-module, `bin_fifo`, instantiated 4 times, one per bin. It is a DEPTH×DATA_W storage with write pointer, read pointer, count, full/empty flags and a synchronous clear.
- Classification and the FSM stay in the top module.

Test Plan:
- Basic frame: defaults; stream 5,4,2,1,10,0,12,3, with last on 3, out_ready held 1 → output sequence:
  - (0,b0), (12,b0), (3,b1), (4,b2), (2,b2), (10,b2), (5,b3), (1,b3, out_last);
  - done pulses one cycle later; overflow=0, drop_count=0.
- Overflow: DEPTH=4; stream 1,5,7,11,13 (last) → bin3 holds 1,5,7,11; overflow=1, drop_count=1; in_ready stays 1 throughout COLLECT; drain outputs 4 beats.
- Backpressure: basic frame with out_ready toggled 1,0,0,1,… → out_data/out_bin stable during stalls; same 8-beat sequence; no duplicates or losses.
- Empty/zero frame:
  - With ZERO_DROP_EN, stream 0,0 (last) → no output beats; done pulses 1 cycle after DRAIN entry.
  - Without the macro → drains (0,b0), (0,b0, last).
- Reset mid-drain: basic frame, assert reset after 3 output beats → next cycle all outputs 0, in_ready=1 after release; a new frame 9 (last) drains (9,b1, last) only.
- Back-to-back frames: second frame 6,7 (last) presented right after done → (6,b0), (7,b3, last); no residue from the first frame.
